nl_op_scheduler: RTL and testbench
==================================

NL_OP_SCHEDULER -- requirements
Module: nl_op_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: command FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 255: max WAIT cycles before abort (1..255).
REQ-003 SHALL have parameter TAG_W, default 4: command tag width.
REQ-004 SHALL have ports:
 - clk_p  in  1  single clock, all logic rising-edge.
 - rst_p  in  1  synchronous, active-high reset.
 - cmd_valid  in  1  command offered (active-high).
 - cmd_ready  out  1  FIFO can accept.
 - cmd_op  in  2  0=LN, 1=GELU, 2=SOFTMAX, 3=reserved.
 - cmd_tag  in  TAG_W  echoed in response.
 - cmd_dim  in  8  softmax valid dimension.
 - ln_valid_n / gelu_valid_n / sm_valid_n  out  1 each  active-low start strobe to unit.
 - ln_done_n / gelu_done_n / sm_done_n  in  1 each  active-low result-valid from unit.
 - sm_dim  out  8  INPUT_DIMENSION to softmax unit.
 - rsp_valid  out  1  one-cycle completion pulse.
 - rsp_tag  out  TAG_W  tag of completed command.
 - rsp_status  out  2  00=OK, 01=TIMEOUT, 10=ILLEGAL.
 - busy  out  1  high when state != IDLE or FIFO non-empty.
 - err_cnt  out  8  saturating count of non-OK responses.

Function
REQ-005 SHALL push {op,tag,dim} into FIFO on a clock edge where cmd_valid && cmd_ready.
REQ-006 SHALL drive cmd_ready = (FIFO count != FIFO_DEPTH), no combinational dependence on pop or cmd_valid.
REQ-007 SHALL, when full, ignore cmd_valid; a pop in the same cycle does not admit a push that cycle.
REQ-008 SHALL support simultaneous push and pop when not full; count unchanged, pointers wrap modulo FIFO_DEPTH.
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-010 IDLE: if FIFO non-empty, pop head into op/tag/dim registers; next state ISSUE if legal, RESP with ILLEGAL otherwise.
REQ-011 Illegal: cmd_op==3, or cmd_op==2 with dim==0 or dim>128.
REQ-012 ISSUE: drive exactly the selected unit's valid_n low for exactly one cycle; next state WAIT; timer cleared to 0.
REQ-013 WAIT: timer increments each cycle; selected done_n low -> RESP, status OK; else timer==TIMEOUT-1 -> RESP, status TIMEOUT.
REQ-014 Done and timeout expiry in same cycle -> OK wins.
REQ-015 Done strobes of non-selected units, and any done_n low outside WAIT, SHALL be ignored.
REQ-016 RESP: rsp_valid=1 for exactly one cycle with registered tag/status; next state IDLE; err_cnt increments if status != OK, saturates at 255.
REQ-017 Latency: push accepted in cycle n into empty FIFO while IDLE -> valid_n low in cycle n+2; done_n low sampled in WAIT cycle m -> rsp_valid in cycle m+1.
REQ-018 Illegal command popped in cycle k -> rsp_valid in cycle k+1; no valid_n asserted.
REQ-019 sm_dim SHALL load from dim on every pop and hold until next pop.
REQ-020 At most one command outstanding; back-to-back commands: next pop in the IDLE cycle following RESP.
REQ-021 rsp_tag/rsp_status SHALL hold last response values when rsp_valid low.

Reset
REQ-022 With rst_p high at an edge: state=IDLE, FIFO emptied, timer=0, err_cnt=0, sm_dim=0, rsp_tag=0, rsp_status=00, rsp_valid=0, all valid_n=1.
REQ-023 Reset mid-operation (ISSUE/WAIT/RESP) SHALL abandon the command with no response; cmd_ready=1 in the cycle after reset deasserts.

Verification
REQ-024 GELU cmd (tag=5) into idle block, gelu_done_n low 10 cycles after strobe -> single gelu_valid_n pulse at n+2, rsp_valid with tag=5, status=00; ln/sm strobes stay 1.
REQ-025 SOFTMAX cmd dim=129 and op=3 cmd -> two ILLEGAL responses, no strobes, err_cnt=2; dim=128 -> strobe, sm_dim=128.
REQ-026 LN cmd, no done, TIMEOUT=255 -> rsp status=01 exactly 256 cycles after strobe cycle; done arriving on the expiry cycle -> status 00.
REQ-027 Push 6 cmds back-to-back while first waits -> cmd_ready low after 4 queued; responses in push order with matching tags.
REQ-028 Assert rst_p during WAIT with 3 queued cmds -> no rsp_valid, busy=0, all outputs at reset values; late done_n ignored.
REQ-029 Force 300 timeouts -> err_cnt saturates at 255.

Source files
------------

// File: rtl/nl_op_scheduler.sv
// nl_op_scheduler: queues nonlinear-op commands and runs them one at a time on the
// LN / GELU / SOFTMAX units, reporting OK, TIMEOUT or ILLEGAL per command.
module nl_op_scheduler #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255,
   parameter int TAG_W      = 4
) (
   input  logic             clk_p,
   input  logic             rst_p,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [TAG_W-1:0] cmd_tag,
   input  logic [7:0]       cmd_dim,
   output logic             ln_valid_n,
   output logic             gelu_valid_n,
   output logic             sm_valid_n,
   input  logic             ln_done_n,
   input  logic             gelu_done_n,
   input  logic             sm_done_n,
   output logic [7:0]       sm_dim,
   output logic             rsp_valid,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [1:0]       rsp_status,
   output logic             busy,
   output logic [7:0]       err_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 2 + TAG_W + 8;

   localparam logic [1:0] OP_LN   = 2'd0;
   localparam logic [1:0] OP_GELU = 2'd1;
   localparam logic [1:0] OP_SM   = 2'd2;
   localparam logic [1:0] OP_RSV  = 2'd3;

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_TMO = 2'b01;
   localparam logic [1:0] ST_ILL = 2'b10;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state, state_nxt;
   logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push, pop;
   logic [1:0]       head_op;
   logic [TAG_W-1:0] head_tag;
   logic [7:0]       head_dim;
   logic [1:0]       op_q;
   logic [TAG_W-1:0] tag_q;
   logic [7:0]       timer;
   logic             sel_done, expired;
   logic             load_rsp;
   logic [TAG_W-1:0] rsp_tag_nxt;
   logic [1:0]       rsp_status_nxt;

   function automatic logic cmd_legal(input logic [1:0] op, input logic [7:0] dim);
      if (op == OP_RSV) return 1'b0;
      if (op == OP_SM && (dim == 8'd0 || dim > 8'd128)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Command FIFO: ready depends only on the registered count
   assign cmd_ready = (count != CNT_W'(FIFO_DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign {head_op, head_tag, head_dim} = fifo_mem[rd_ptr];

   always_ff @(posedge clk_p) begin
      if (push) fifo_mem[wr_ptr] <= {cmd_op, cmd_tag, cmd_dim};
   end

   always_ff @(posedge clk_p) begin
      if (rst_p) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      case (op_q)
         OP_LN:   sel_done = !ln_done_n;
         OP_GELU: sel_done = !gelu_done_n;
         OP_SM:   sel_done = !sm_done_n;
         default: sel_done = 1'b0;
      endcase
   end

   assign expired = (timer == 8'(TIMEOUT - 1));
   assign busy    = (state != IDLE) || (count != '0);

   always_ff @(posedge clk_p) begin
      if (rst_p) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      pop            = 1'b0;
      load_rsp       = 1'b0;
      rsp_tag_nxt    = tag_q;
      rsp_status_nxt = ST_OK;
      ln_valid_n     = 1'b1;
      gelu_valid_n   = 1'b1;
      sm_valid_n     = 1'b1;
      rsp_valid      = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop = 1'b1;
               if (cmd_legal(head_op, head_dim)) begin
                  state_nxt = ISSUE;
               end else begin
                  // Illegal commands never reach a unit; report straight from the head entry
                  state_nxt      = RESP;
                  load_rsp       = 1'b1;
                  rsp_tag_nxt    = head_tag;
                  rsp_status_nxt = ST_ILL;
               end
            end
         end
         ISSUE: begin
            ln_valid_n   = (op_q != OP_LN);
            gelu_valid_n = (op_q != OP_GELU);
            sm_valid_n   = (op_q != OP_SM);
            state_nxt    = WAIT;
         end
         WAIT: begin
            if (sel_done) begin
               state_nxt = RESP;
               load_rsp  = 1'b1;
            end else if (expired) begin
               state_nxt      = RESP;
               load_rsp       = 1'b1;
               rsp_status_nxt = ST_TMO;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_p) begin
      if (pop) begin
         op_q  <= head_op;
         tag_q <= head_tag;
      end
   end

   always_ff @(posedge clk_p) begin
      if (rst_p) begin
         sm_dim     <= 8'd0;
         rsp_tag    <= '0;
         rsp_status <= ST_OK;
         err_cnt    <= 8'd0;
         timer      <= 8'd0;
      end else begin
         if (pop) sm_dim <= head_dim;
         if (load_rsp) begin
            rsp_tag    <= rsp_tag_nxt;
            rsp_status <= rsp_status_nxt;
         end
         if (state == ISSUE)     timer <= 8'd0;
         else if (state == WAIT) timer <= timer + 8'd1;
         if (state == RESP && rsp_status != ST_OK) err_cnt <= sat_inc8(err_cnt);
      end
   end

endmodule

// File: tb/tb_nl_op_scheduler.sv
// Directed bench for nl_op_scheduler: scoreboard of expected {tag,status} per command,
// checked as responses appear, plus strobe-timing and reset/saturation checks.
module tb_nl_op_scheduler;

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_TMO = 2'b01;
   localparam logic [1:0] ST_ILL = 2'b10;

   logic       clk_p = 1'b0;
   logic       rst_p = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'd0;
   logic [3:0] cmd_tag = 4'd0;
   logic [7:0] cmd_dim = 8'd0;
   logic       ln_valid_n, gelu_valid_n, sm_valid_n;
   logic       ln_done_n = 1'b1, gelu_done_n = 1'b1, sm_done_n = 1'b1;
   logic [7:0] sm_dim;
   logic       rsp_valid;
   logic [3:0] rsp_tag;
   logic [1:0] rsp_status;
   logic       busy;
   logic [7:0] err_cnt;

   nl_op_scheduler #(.FIFO_DEPTH(4), .TIMEOUT(255), .TAG_W(4)) dut (
      .clk_p(clk_p), .rst_p(rst_p),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_tag(cmd_tag), .cmd_dim(cmd_dim),
      .ln_valid_n(ln_valid_n), .gelu_valid_n(gelu_valid_n), .sm_valid_n(sm_valid_n),
      .ln_done_n(ln_done_n), .gelu_done_n(gelu_done_n), .sm_done_n(sm_done_n),
      .sm_dim(sm_dim),
      .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_status(rsp_status),
      .busy(busy), .err_cnt(err_cnt)
   );

   always #5 clk_p = ~clk_p;

   typedef struct {
      logic [3:0] etag;
      logic [1:0] est;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0, n_fail = 0;
   int   cyc = 0, push_cyc = 0;
   int   ln_cnt = 0, gelu_cnt = 0, sm_cnt = 0, ln_last = 0, gelu_last = 0, sm_last = 0;
   int   rsp_cnt = 0, rsp_last = 0;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
      end
   endtask

   // One clock: outputs are sampled 1 time unit after the rising edge
   task automatic tick();
      exp_t e;
      @(posedge clk_p);
      #1;
      cyc++;
      if (ln_valid_n === 1'b0)   begin ln_cnt++;   ln_last = cyc;   end
      if (gelu_valid_n === 1'b0) begin gelu_cnt++; gelu_last = cyc; end
      if (sm_valid_n === 1'b0)   begin sm_cnt++;   sm_last = cyc;   end
      if (rsp_valid === 1'b1) begin
         rsp_cnt++;
         rsp_last = cyc;
         if (sb.size() == 0) begin
            chk("rsp_unexpected", rsp_cnt, 0);
         end else begin
            e = sb.pop_front();
            chk("rsp_tag", rsp_tag, e.etag);
            chk("rsp_status", rsp_status, e.est);
         end
      end
   endtask

   task automatic push_cmd(input logic [1:0] op, input logic [3:0] tag, input logic [7:0] dim,
                           input logic [1:0] st);
      int   i = 0;
      logic acc = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_tag   = tag;
      cmd_dim   = dim;
      sb.push_back('{etag: tag, est: st});
      while (!acc && i < 600) begin
         acc      = cmd_ready;
         push_cyc = cyc;
         tick();
         i++;
      end
      cmd_valid = 1'b0;
      chk("push_accept", acc, 1);
   endtask

   task automatic wait_strobe(input int budget);
      int start = ln_cnt + gelu_cnt + sm_cnt;
      int i = 0;
      while ((ln_cnt + gelu_cnt + sm_cnt) == start && i < budget) begin
         tick();
         i++;
      end
      chk("strobe_seen", (ln_cnt + gelu_cnt + sm_cnt) != start, 1);
   endtask

   task automatic wait_rsp(input int target, input int budget);
      int i = 0;
      while (rsp_cnt < target && i < budget) begin
         tick();
         i++;
      end
      chk("rsp_arrived", rsp_cnt >= target, 1);
   endtask

   initial begin
      int s, p1, base;

      // Reset values
      tick();
      tick();
      rst_p = 1'b0;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_sm_dim", sm_dim, 0);
      chk("rst_rsp_tag", rsp_tag, 0);
      chk("rst_rsp_status", rsp_status, 0);
      chk("rst_valid_n", {ln_valid_n, gelu_valid_n, sm_valid_n}, 3'b111);

      // GELU tag 5, done 10 cycles after the strobe
      push_cmd(2'd1, 4'd5, 8'd0, ST_OK);
      wait_strobe(10);
      chk("gelu_strobe_latency", gelu_last, push_cyc + 2);
      s = gelu_last;
      repeat (10) tick();
      gelu_done_n = 1'b0;
      tick();
      gelu_done_n = 1'b1;
      chk("gelu_rsp_latency", rsp_last, s + 11);
      chk("gelu_rsp_count", rsp_cnt, 1);
      chk("gelu_strobe_once", gelu_cnt, 1);
      chk("gelu_no_other", ln_cnt + sm_cnt, 0);
      tick();
      chk("rsp_pulse_one_cycle", rsp_valid, 0);
      chk("rsp_tag_hold", rsp_tag, 5);

      // Illegal: SOFTMAX dim 129 and reserved op
      push_cmd(2'd2, 4'd1, 8'd129, ST_ILL);
      p1 = push_cyc;
      push_cmd(2'd3, 4'd2, 8'd0, ST_ILL);
      chk("illegal_rsp_latency", rsp_last, p1 + 2);
      wait_rsp(3, 20);
      tick();
      chk("illegal_err_cnt", err_cnt, 2);
      chk("illegal_no_strobe", ln_cnt + gelu_cnt + sm_cnt, 1);

      // SOFTMAX dim 128 is legal; other units' done strobes are ignored
      push_cmd(2'd2, 4'd3, 8'd128, ST_OK);
      wait_strobe(10);
      chk("sm_strobe", sm_cnt, 1);
      chk("sm_dim_128", sm_dim, 128);
      ln_done_n   = 1'b0;
      gelu_done_n = 1'b0;
      repeat (3) tick();
      ln_done_n   = 1'b1;
      gelu_done_n = 1'b1;
      chk("foreign_done_ignored", rsp_cnt, 3);
      sm_done_n = 1'b0;
      wait_rsp(4, 5);
      sm_done_n = 1'b1;
      chk("sm_err_unchanged", err_cnt, 2);

      // LN timeout exactly 256 cycles after the strobe
      push_cmd(2'd0, 4'd6, 8'd0, ST_TMO);
      wait_strobe(10);
      s = ln_last;
      wait_rsp(5, 300);
      chk("timeout_latency", rsp_last, s + 256);
      tick();
      chk("timeout_err_cnt", err_cnt, 3);

      // Done on the expiry cycle wins
      push_cmd(2'd0, 4'd7, 8'd0, ST_OK);
      wait_strobe(10);
      s = ln_last;
      repeat (255) tick();
      ln_done_n = 1'b0;
      tick();
      ln_done_n = 1'b1;
      chk("expiry_done_latency", rsp_last, s + 256);
      chk("expiry_done_count", rsp_cnt, 6);

      // Six back-to-back GELU commands while the first waits
      base = rsp_cnt;
      for (int i = 0; i < 5; i++) push_cmd(2'd1, 4'(8 + i), 8'd0, ST_OK);
      chk("full_ready_low", cmd_ready, 0);
      repeat (3) tick();
      chk("full_ready_held", cmd_ready, 0);
      chk("full_busy", busy, 1);
      gelu_done_n = 1'b0;
      push_cmd(2'd1, 4'd13, 8'd0, ST_OK);
      wait_rsp(base + 6, 100);
      gelu_done_n = 1'b1;
      chk("b2b_sb_empty", sb.size(), 0);

      // Reset during WAIT with three queued commands
      push_cmd(2'd0, 4'd1, 8'd0, ST_OK);
      wait_strobe(10);
      for (int i = 0; i < 3; i++) push_cmd(2'd0, 4'(2 + i), 8'd0, ST_OK);
      tick();
      rst_p = 1'b1;
      sb.delete();
      tick();
      rst_p = 1'b0;
      base = rsp_cnt;
      s    = ln_cnt;
      chk("mid_rst_ready", cmd_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_err_cnt", err_cnt, 0);
      chk("mid_rst_sm_dim", sm_dim, 0);
      chk("mid_rst_rsp_tag", rsp_tag, 0);
      chk("mid_rst_rsp_status", rsp_status, 0);
      chk("mid_rst_valid_n", {ln_valid_n, gelu_valid_n, sm_valid_n}, 3'b111);
      ln_done_n = 1'b0;
      repeat (5) tick();
      ln_done_n = 1'b1;
      chk("late_done_no_rsp", rsp_cnt, base);
      chk("late_done_no_strobe", ln_cnt, s);
      chk("late_done_busy", busy, 0);

      // err_cnt saturation: 252 illegal, then timeouts across the 255 boundary
      base = rsp_cnt;
      for (int i = 0; i < 252; i++) push_cmd(2'd3, 4'(i), 8'd0, ST_ILL);
      wait_rsp(base + 252, 100);
      tick();
      chk("sat_err_252", err_cnt, 252);
      push_cmd(2'd0, 4'd9, 8'd0, ST_TMO);
      push_cmd(2'd0, 4'd10, 8'd0, ST_TMO);
      wait_rsp(base + 254, 600);
      tick();
      chk("sat_err_254", err_cnt, 254);
      for (int i = 0; i < 3; i++) push_cmd(2'd0, 4'(11 + i), 8'd0, ST_TMO);
      wait_rsp(base + 257, 900);
      tick();
      chk("sat_err_255", err_cnt, 255);
      chk("sat_sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
